decode_ctrl_stage: RTL and testbench
====================================

Name: decode_ctrl_stage

Overview:
- Parametrised next-generation main decoder for the 5-stage MIPS pipeline.
- Decodes IR_D and drives the D-stage PC-redirect controls combinationally.
- Registers the E/M/W control bundle into the D/E pipeline register.
- Adds a multiply/divide busy counter with HI/LO hazard stall, bubble insertion on stall or flush, and a reserved-instruction flag.

Parameters:
- ALUOP_W, 3, width of ALUOp field.
- MULT_CYCLES, 5, busy cycles after mult/multu enters E; legal range 1..31.
- DIV_CYCLES, 10, busy cycles after div/divu enters E; legal range 1..31.
- CNT_W, 5, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high.
- IR_D  in  32  instruction in D stage.
- valid_D  in  1  IR_D is a real instruction; 0 means treat as nop.
- flush_E  in  1  force bubble into E next edge.
- EXTSrc_D  out  2  immediate extend select: 0 sign, 1 zero, 2 lui-shift. Combinational.
- Branch_D, Jump_D, jr_D, PCSrc_D  out  1 each  D-stage redirect controls. Combinational.
- stall_D  out  1  freeze PC and F/D register. Combinational.
- ALU_BSrc_E  out  1  registered.
- ALUOp_E  out  ALUOP_W  registered: 0 add, 1 sub, 2 or, 3 lui, 4 R-funct.
- MemWrite_E, RegWrite_E  out  1 each  registered.
- WASrc_E  out  2  registered: 0 rt, 1 rd, 2 $31.
- WDSrc_E  out  2  registered: 0 mem, 1 alu, 2 PC+8, 3 HI/LO.
- MDOp_E  out  3  registered: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
- HLSel_E  out  1  registered: mfhi 1, mflo 0.
- RI_E  out  1  registered reserved-instruction flag.
- md_busy  out  1  busy counter nonzero.

Behaviour:
- Decoded set:
  - R-type funct: addu 0x21, subu 0x23, jr 0x08, mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mfhi 0x10, mflo 0x12, mthi 0x11, mtlo 0x13.
  - Opcodes: lw 0x23, sw 0x2B, ori 0x0D, lui 0x0F, beq 0x04, j 0x02, jal 0x03.
- Nop and unknown encodings:
  - IR_D==0, or valid_D=0: every control 0, RI 0.
  - Any other op/funct not listed: controls 0, RI=1.
- Control values per instruction:
  - addu/subu: RegWrite, WASrc=1, WDSrc=1, ALUOp=4.
  - lw: ALU_BSrc, ALUOp=0, RegWrite, WASrc=0, WDSrc=0.
  - sw: ALU_BSrc, ALUOp=0, MemWrite.
  - ori: EXTSrc=1, ALU_BSrc, ALUOp=2, RegWrite, WDSrc=1.
  - lui: EXTSrc=2, ALU_BSrc, ALUOp=3, RegWrite, WDSrc=1.
  - beq: Branch, PCSrc.
  - j: Jump, PCSrc.
  - jal: Jump, PCSrc, RegWrite, WASrc=2, WDSrc=2.
  - jr: Jump, jr, PCSrc.
  - mf*: RegWrite, WASrc=1, WDSrc=3, HLSel.
  - mult/div/mt*: MDOp only.
- hilo_use_D: decoded IR_D is any of mult*, div*, mf*, mt*.
- stall_D = hilo_use_D AND md_busy. It is combinational, same cycle.
- D-stage outputs (EXTSrc, Branch, Jump, jr, PCSrc) are forced to 0 while stall_D=1.
- E register update at posedge clk, in priority order:
  1. reset: all E outputs 0.
  2. flush_E or stall_D: bubble, all E outputs 0.
  3. Otherwise: decoded bundle.
- Busy counter cnt, updated at posedge clk:
  1. reset: cnt=0.
  2. An instruction with MDOp 1/2 is registered into E (not bubbled): cnt = MULT_CYCLES.
  3. An instruction with MDOp 3/4 is registered into E (not bubbled): cnt = DIV_CYCLES.
  4. cnt != 0: cnt = cnt - 1.
  5. Otherwise cnt holds.
- md_busy = (cnt != 0) OR (MDOp_E in 1..4). The start cycle therefore already blocks.
- mthi/mtlo do not load the counter.
- Load and decrement never coincide, because an md start stalls while busy.
- Simultaneous stall_D and flush_E: bubble. The counter is not loaded.
- Reset mid-busy clears cnt and the E register the next edge; stall_D drops that cycle.
- No E-stage output changes except at posedge clk. Latency from IR_D to E outputs is 1 cycle.

Test Plan:
- Reset: hold reset 2 cycles with IR_D=0x02000018 (mult) → all E outputs 0, md_busy 0, stall_D 0.
- addu $3,$1,$2 (0x00221821), then lw (0x8C230004) → next edge RegWrite_E=1, WASrc_E=1, WDSrc_E=1, ALUOp_E=4; following edge ALU_BSrc_E=1, WASrc_E=0, WDSrc_E=0.
- mult (0x00220018), then mflo (0x00001812) held in D → stall_D=1 for exactly MULT_CYCLES+1=6 cycles, E bubbles during stall, then mflo registers with WDSrc_E=3, HLSel_E=0.
- divu (0x0022001B), then addu → no stall; md_busy stays 1 for 11 cycles (including the start cycle), then 0.
- jal (0x0C000010) → Jump_D=PCSrc_D=1 same cycle; next edge RegWrite_E=1, WASrc_E=2, WDSrc_E=2. Repeat with flush_E=1 → E outputs all 0.
- Illegal opcode 0xFC000000 → RI_E=1 with all other controls 0. Assert reset at cycle 3 of a div busy period → cnt cleared, md_busy 0 next cycle.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// Main decoder for the D stage of a 5-stage MIPS pipeline: combinational PC-redirect
// controls, registered E/M/W control bundle, and a mult/div busy counter that stalls HI/LO users.
module decode_ctrl_stage #(
  parameter int ALUOP_W     = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        IR_D,
  input  logic               valid_D,
  input  logic               flush_E,
  output logic [1:0]         EXTSrc_D,
  output logic               Branch_D,
  output logic               Jump_D,
  output logic               jr_D,
  output logic               PCSrc_D,
  output logic               stall_D,
  output logic               ALU_BSrc_E,
  output logic [ALUOP_W-1:0] ALUOp_E,
  output logic               MemWrite_E,
  output logic               RegWrite_E,
  output logic [1:0]         WASrc_E,
  output logic [1:0]         WDSrc_E,
  output logic [2:0]         MDOp_E,
  output logic               HLSel_E,
  output logic               RI_E,
  output logic               md_busy
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F, OP_BEQ = 6'h04, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_JR = 6'h08, FN_MULT = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B, FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12, FN_MTHI = 6'h11, FN_MTLO = 6'h13;

  localparam logic [2:0] MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_DIV = 3'd3, MD_DIVU = 3'd4;
  localparam logic [2:0] MD_MTHI = 3'd5, MD_MTLO = 3'd6;

  typedef struct packed {
    logic               alu_bsrc;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         wa_src;
    logic [1:0]         wd_src;
    logic [2:0]         md_op;
    logic               hl_sel;
    logic               ri;
  } ectl_t;

  ectl_t            dec_d;
  ectl_t            e_q;
  logic [1:0]       ext_src_d;
  logic             branch_d;
  logic             jump_d;
  logic             jr_d;
  logic             pcsrc_d;
  logic             hilo_use_d;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             md_start_e;

  assign op    = IR_D[31:26];
  assign funct = IR_D[5:0];

  always_comb begin
    dec_d      = '0;
    ext_src_d  = 2'd0;
    branch_d   = 1'b0;
    jump_d     = 1'b0;
    jr_d       = 1'b0;
    pcsrc_d    = 1'b0;
    hilo_use_d = 1'b0;
    if (valid_D && (IR_D != 32'd0)) begin
      case (op)
        OP_RTYPE: begin
          case (funct)
            FN_ADDU, FN_SUBU: begin
              dec_d.reg_write = 1'b1;
              dec_d.wa_src    = 2'd1;
              dec_d.wd_src    = 2'd1;
              dec_d.alu_op    = ALUOP_W'(4);
            end
            FN_JR: begin
              jump_d  = 1'b1;
              jr_d    = 1'b1;
              pcsrc_d = 1'b1;
            end
            FN_MULT:  begin dec_d.md_op = MD_MULT;  hilo_use_d = 1'b1; end
            FN_MULTU: begin dec_d.md_op = MD_MULTU; hilo_use_d = 1'b1; end
            FN_DIV:   begin dec_d.md_op = MD_DIV;   hilo_use_d = 1'b1; end
            FN_DIVU:  begin dec_d.md_op = MD_DIVU;  hilo_use_d = 1'b1; end
            FN_MTHI:  begin dec_d.md_op = MD_MTHI;  hilo_use_d = 1'b1; end
            FN_MTLO:  begin dec_d.md_op = MD_MTLO;  hilo_use_d = 1'b1; end
            FN_MFHI, FN_MFLO: begin
              dec_d.reg_write = 1'b1;
              dec_d.wa_src    = 2'd1;
              dec_d.wd_src    = 2'd3;
              dec_d.hl_sel    = (funct == FN_MFHI);
              hilo_use_d      = 1'b1;
            end
            default: dec_d.ri = 1'b1;
          endcase
        end
        OP_LW: begin
          dec_d.alu_bsrc  = 1'b1;
          dec_d.reg_write = 1'b1;
        end
        OP_SW: begin
          dec_d.alu_bsrc  = 1'b1;
          dec_d.mem_write = 1'b1;
        end
        OP_ORI: begin
          ext_src_d       = 2'd1;
          dec_d.alu_bsrc  = 1'b1;
          dec_d.alu_op    = ALUOP_W'(2);
          dec_d.reg_write = 1'b1;
          dec_d.wd_src    = 2'd1;
        end
        OP_LUI: begin
          ext_src_d       = 2'd2;
          dec_d.alu_bsrc  = 1'b1;
          dec_d.alu_op    = ALUOP_W'(3);
          dec_d.reg_write = 1'b1;
          dec_d.wd_src    = 2'd1;
        end
        OP_BEQ: begin
          branch_d = 1'b1;
          pcsrc_d  = 1'b1;
        end
        OP_J: begin
          jump_d  = 1'b1;
          pcsrc_d = 1'b1;
        end
        OP_JAL: begin
          jump_d          = 1'b1;
          pcsrc_d         = 1'b1;
          dec_d.reg_write = 1'b1;
          dec_d.wa_src    = 2'd2;
          dec_d.wd_src    = 2'd2;
        end
        default: dec_d.ri = 1'b1;
      endcase
    end
  end

  // The md op sitting in E counts as busy before the counter has been loaded.
  assign md_start_e = (e_q.md_op != 3'd0) && (e_q.md_op <= MD_DIVU);
  assign md_busy    = (cnt_q != '0) || md_start_e;
  assign stall_D    = hilo_use_d && md_busy;

  assign EXTSrc_D = stall_D ? 2'd0 : ext_src_d;
  assign Branch_D = branch_d && !stall_D;
  assign Jump_D   = jump_d && !stall_D;
  assign jr_D     = jr_d && !stall_D;
  assign PCSrc_D  = pcsrc_d && !stall_D;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
    end else if (flush_E || stall_D) begin
      e_q <= '0;
    end else begin
      e_q <= dec_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (reset) begin
      cnt_d = '0;
    end else if ((e_q.md_op == MD_MULT) || (e_q.md_op == MD_MULTU)) begin
      cnt_d = CNT_W'(MULT_CYCLES);
    end else if ((e_q.md_op == MD_DIV) || (e_q.md_op == MD_DIVU)) begin
      cnt_d = CNT_W'(DIV_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign ALU_BSrc_E = e_q.alu_bsrc;
  assign ALUOp_E    = e_q.alu_op;
  assign MemWrite_E = e_q.mem_write;
  assign RegWrite_E = e_q.reg_write;
  assign WASrc_E    = e_q.wa_src;
  assign WDSrc_E    = e_q.wd_src;
  assign MDOp_E     = e_q.md_op;
  assign HLSel_E    = e_q.hl_sel;
  assign RI_E       = e_q.ri;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: directed scenarios followed by random instruction streams,
// all checked against a mnemonic-level reference model with a busy-cycle budget.
module tb_decode_ctrl_stage;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_D;
  logic        valid_D;
  logic        flush_E;
  logic [1:0]  EXTSrc_D;
  logic        Branch_D, Jump_D, jr_D, PCSrc_D, stall_D;
  logic        ALU_BSrc_E;
  logic [2:0]  ALUOp_E;
  logic        MemWrite_E, RegWrite_E;
  logic [1:0]  WASrc_E, WDSrc_E;
  logic [2:0]  MDOp_E;
  logic        HLSel_E, RI_E, md_busy;

  decode_ctrl_stage #(
    .ALUOP_W(3), .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .IR_D(IR_D), .valid_D(valid_D), .flush_E(flush_E),
    .EXTSrc_D(EXTSrc_D), .Branch_D(Branch_D), .Jump_D(Jump_D), .jr_D(jr_D),
    .PCSrc_D(PCSrc_D), .stall_D(stall_D), .ALU_BSrc_E(ALU_BSrc_E), .ALUOp_E(ALUOp_E),
    .MemWrite_E(MemWrite_E), .RegWrite_E(RegWrite_E), .WASrc_E(WASrc_E),
    .WDSrc_E(WDSrc_E), .MDOp_E(MDOp_E), .HLSel_E(HLSel_E), .RI_E(RI_E), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       bsrc;
    logic [2:0] aluop;
    logic       mw;
    logic       rw;
    logic [1:0] wa;
    logic [1:0] wd;
    logic [2:0] md;
    logic       hl;
    logic       ri;
  } e_t;

  typedef struct packed {
    logic [1:0] ext;
    logic       br, jmp, jr, pcs, hilo;
    e_t         e;
  } ref_t;

  int   checks = 0;
  int   errors = 0;
  e_t   exp_e = '0;
  int   busy_left = 0;   // cycles (including the current one) md_busy must still read 1
  logic last_stall, last_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic string mnem(input logic [31:0] ir, input logic v);
    logic [5:0] op, fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (!v || ir == 32'd0) return "nop";
    if (op == 6'h00) begin
      if (fn == 6'h21) return "addu";
      if (fn == 6'h23) return "subu";
      if (fn == 6'h08) return "jr";
      if (fn == 6'h18) return "mult";
      if (fn == 6'h19) return "multu";
      if (fn == 6'h1A) return "div";
      if (fn == 6'h1B) return "divu";
      if (fn == 6'h10) return "mfhi";
      if (fn == 6'h12) return "mflo";
      if (fn == 6'h11) return "mthi";
      if (fn == 6'h13) return "mtlo";
      return "ri";
    end
    if (op == 6'h23) return "lw";
    if (op == 6'h2B) return "sw";
    if (op == 6'h0D) return "ori";
    if (op == 6'h0F) return "lui";
    if (op == 6'h04) return "beq";
    if (op == 6'h02) return "j";
    if (op == 6'h03) return "jal";
    return "ri";
  endfunction

  function automatic ref_t ref_ctl(input logic [31:0] ir, input logic v);
    ref_t  r;
    string m;
    r = '0;
    m = mnem(ir, v);
    if (m == "addu" || m == "subu") begin r.e.rw = 1; r.e.wa = 1; r.e.wd = 1; r.e.aluop = 4; end
    else if (m == "lw")  begin r.e.bsrc = 1; r.e.rw = 1; end
    else if (m == "sw")  begin r.e.bsrc = 1; r.e.mw = 1; end
    else if (m == "ori") begin r.ext = 1; r.e.bsrc = 1; r.e.aluop = 2; r.e.rw = 1; r.e.wd = 1; end
    else if (m == "lui") begin r.ext = 2; r.e.bsrc = 1; r.e.aluop = 3; r.e.rw = 1; r.e.wd = 1; end
    else if (m == "beq") begin r.br = 1; r.pcs = 1; end
    else if (m == "j")   begin r.jmp = 1; r.pcs = 1; end
    else if (m == "jal") begin r.jmp = 1; r.pcs = 1; r.e.rw = 1; r.e.wa = 2; r.e.wd = 2; end
    else if (m == "jr")  begin r.jmp = 1; r.jr = 1; r.pcs = 1; end
    else if (m == "mfhi" || m == "mflo") begin
      r.e.rw = 1; r.e.wa = 1; r.e.wd = 3; r.e.hl = (m == "mfhi"); r.hilo = 1;
    end
    else if (m == "mult")  begin r.e.md = 1; r.hilo = 1; end
    else if (m == "multu") begin r.e.md = 2; r.hilo = 1; end
    else if (m == "div")   begin r.e.md = 3; r.hilo = 1; end
    else if (m == "divu")  begin r.e.md = 4; r.hilo = 1; end
    else if (m == "mthi")  begin r.e.md = 5; r.hilo = 1; end
    else if (m == "mtlo")  begin r.e.md = 6; r.hilo = 1; end
    else if (m == "ri")    r.e.ri = 1;
    return r;
  endfunction

  // One clock cycle: drive, check D-stage outputs mid-cycle, advance model, check E just after edge.
  task automatic step(input logic [31:0] ir, input logic v, input logic fl, input logic rst);
    ref_t r;
    logic busy_m, stall_m, bubble;
    IR_D = ir; valid_D = v; flush_E = fl; reset = rst;
    #2;
    r       = ref_ctl(ir, v);
    busy_m  = (busy_left > 0);
    stall_m = r.hilo && busy_m;
    chk("stall_D", 32'(stall_D), 32'(stall_m));
    chk("md_busy", 32'(md_busy), 32'(busy_m));
    chk("D_ctl", 32'({EXTSrc_D, Branch_D, Jump_D, jr_D, PCSrc_D}),
        stall_m ? 32'd0 : 32'({r.ext, r.br, r.jmp, r.jr, r.pcs}));
    last_stall = stall_D;
    last_busy  = md_busy;
    @(posedge clk);
    bubble = fl || stall_m;
    if (rst) begin
      exp_e     = '0;
      busy_left = 0;
    end else begin
      exp_e = bubble ? e_t'(0) : r.e;
      if (!bubble && r.e.md >= 1 && r.e.md <= 4)
        busy_left = ((r.e.md <= 2) ? MULT_CYCLES : DIV_CYCLES) + 1;
      else if (busy_left > 0)
        busy_left--;
    end
    #1;
    chk("E_bundle", 32'({ALU_BSrc_E, ALUOp_E, MemWrite_E, RegWrite_E, WASrc_E, WDSrc_E,
                          MDOp_E, HLSel_E, RI_E}), 32'(exp_e));
    $display("ir=%h v=%0d fl=%0d rst=%0d stall=%0d busy=%0d E=%h", ir, v, fl, rst,
             last_stall, last_busy, 32'(exp_e));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] rt_pool [11] = '{32'h21, 32'h23, 32'h08, 32'h18, 32'h19, 32'h1A, 32'h1B,
                                  32'h10, 32'h12, 32'h11, 32'h13};
    logic [5:0]  op_pool [7]  = '{6'h23, 6'h2B, 6'h0D, 6'h0F, 6'h04, 6'h02, 6'h03};
    logic [31:0] rnd;
    int          sel;
    rnd = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0) return rnd;
    if (sel == 1) return 32'd0;
    if (sel <= 5) return rt_pool[$urandom_range(0, 10)] | (rnd & 32'h03FF_FFC0);
    if (sel == 6) return {6'h00, rnd[25:0]};
    return {op_pool[$urandom_range(0, 6)], rnd[25:0]};
  endfunction

  localparam logic [31:0] I_ADDU = 32'h0022_1821, I_LW = 32'h8C23_0004, I_MULT = 32'h0022_0018;
  localparam logic [31:0] I_MFLO = 32'h0000_1812, I_DIVU = 32'h0022_001B, I_JAL = 32'h0C00_0010;
  localparam logic [31:0] I_DIV  = 32'h0022_001A, I_BAD = 32'hFC00_0000;

  initial begin
    int n;
    int cnt;
    reset = 1'b1; IR_D = 32'h0200_0018; valid_D = 1'b1; flush_E = 1'b0;
    @(posedge clk); #1;
    step(32'h0200_0018, 1, 0, 1);

    step(I_ADDU, 1, 0, 0);
    step(I_LW, 1, 0, 0);

    step(I_MULT, 1, 0, 0);
    cnt = 0;
    n   = 0;
    do begin
      step(I_MFLO, 1, 0, 0);
      if (last_stall) cnt++;
      n++;
    end while (last_stall && n < 20);
    chk("mflo_stall_cycles", 32'(cnt), 32'(MULT_CYCLES + 1));
    chk("mflo_E", 32'({WDSrc_E, HLSel_E, RegWrite_E}), 32'({2'd3, 1'b0, 1'b1}));

    step(I_DIVU, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(I_ADDU, 1, 0, 0);
      if (last_busy) cnt++;
    end
    chk("divu_busy_cycles", 32'(cnt), 32'(DIV_CYCLES + 1));

    step(I_JAL, 1, 0, 0);
    step(I_JAL, 1, 1, 0);
    step(I_BAD, 1, 0, 0);
    step(32'd0, 1, 0, 0);

    step(I_DIV, 1, 0, 0);
    step(I_ADDU, 1, 0, 0);
    step(I_ADDU, 1, 0, 0);
    step(I_ADDU, 1, 0, 1);
    step(I_ADDU, 1, 0, 0);
    chk("busy_after_reset", 32'(last_busy), 32'd0);

    for (int i = 0; i < 600; i++) begin
      step(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
